// File: rtl/product_accumulator.sv
// product_accumulator
//
// Sums COUNT unsigned 2N-bit products from the multiplier into one W-bit
// frame result. The result is offered on an output valid/ready handshake.
// The block does not accept new products while a result is held. The next
// frame starts only after the result is taken.
//
// Parameters:
//   N      multiplier operand width (product input is 2N bits)
//   COUNT  products per frame (>= 1)
//   W      accumulator / result width (>= 2N)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort; overrides every other event
//   in_valid   product available
//   in_ready   product accepted this cycle (high only while accumulating)
//   in_p       unsigned 2N-bit product
//   out_valid  frame result available
//   out_ready  consumer takes the result
//   out_sum    frame sum (reads 0 while accumulating)
//   out_ovf    at least one carry out of W bits occurred in the frame
//
// Configuration macro:
//   SAT_ACCUM_EN  defined   -> accumulator clamps to 2^W-1 on carry-out
//                 undefined -> accumulator wraps modulo 2^W
module product_accumulator #(
  parameter int N     = 4,
  parameter int COUNT = 4,
  parameter int W     = 2*N+2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_sum,
  output logic           out_ovf
);

  localparam int CNT_W = $clog2(COUNT+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT-1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             sovf_q, sovf_d;

  // W+1-bit sum of accumulator and zero-extended product; the MSB is the
  // carry out of the W-bit accumulator.
  function automatic logic [W:0] add_wide(input logic [W-1:0] a,
                                          input logic [2*N-1:0] p);
    return {1'b0, a} + {{(W+1-2*N){1'b0}}, p};
  endfunction

  // Reduce the widened sum back to W bits. In saturating mode a clamped
  // accumulator stays clamped: any non-zero product carries again, and a
  // zero product leaves 2^W-1 unchanged.
  function automatic logic [W-1:0] sat_or_wrap(input logic [W:0] s);
`ifdef SAT_ACCUM_EN
    return s[W] ? {W{1'b1}} : s[W-1:0];
`else
    return s[W-1:0];
`endif
  endfunction

  logic       in_fire;
  logic       out_fire;
  logic [W:0] acc_wide;

  assign in_fire  = in_valid  && (state_q == ACCUM);
  assign out_fire = out_ready && (state_q == HOLD);
  assign acc_wide = add_wide(acc_q, in_p);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    sovf_d  = sovf_q;

    if (clear) begin
      // Abort: drop any partial frame, any held result and any product
      // presented in this same cycle.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      sum_d   = '0;
      sovf_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_fire) begin
            if (cnt_q == LAST_CNT) begin
              // Final product: publish the result into the output registers
              // and reset the working accumulator for the next frame.
              state_d = HOLD;
              cnt_d   = '0;
              sum_d   = sat_or_wrap(acc_wide);
              sovf_d  = ovf_q | acc_wide[W];
              acc_d   = '0;
              ovf_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
              acc_d = sat_or_wrap(acc_wide);
              ovf_d = ovf_q | acc_wide[W];
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state_d = ACCUM;
            sum_d   = '0;
            sovf_d  = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      sovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      sovf_q  <= sovf_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output
  // combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_ovf   = sovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int N     = 4;
  localparam int COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_p;
  logic       out_ready;

  logic       in_ready_a,  out_valid_a, out_ovf_a;
  logic [9:0] out_sum_a;
  logic       in_ready_b,  out_valid_b, out_ovf_b;
  logic [8:0] out_sum_b;

  int ntot  = 0;
  int nfail = 0;

  // W = 10 (default width) instance
  product_accumulator #(.N(N), .COUNT(COUNT), .W(10)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_p      (in_p),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_sum   (out_sum_a),
    .out_ovf   (out_ovf_a)
  );

  // W = 9 instance, same stimulus, used for the overflow case
  product_accumulator #(.N(N), .COUNT(COUNT), .W(9)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_p      (in_p),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_ovf   (out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    out_ready = 1'b0;

    // ---- reset / idle ----
    tick(); tick();
    chk("rst_in_ready",  in_ready_a,  1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_sum",   out_sum_a,   0);
    chk("rst_out_ovf",   out_ovf_a,   0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready",  in_ready_a,  1);
    chk("idle_out_valid", out_valid_a, 0);

    // ---- basic frame: 225 x4 -> 900 ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_p      = 8'd225;
    tick(); tick();
    chk("basic_mid_out_sum_zero", out_sum_a, 0);
    chk("basic_mid_out_valid",    out_valid_a, 0);
    tick(); tick();
    in_valid = 1'b0;
    chk("basic_out_valid", out_valid_a, 1);
    chk("basic_out_sum",   out_sum_a,   900);
    chk("basic_out_ovf",   out_ovf_a,   0);
    chk("basic_in_ready_low", in_ready_a, 0);
    tick();
    chk("basic_out_valid_1cyc", out_valid_a, 0);
    chk("basic_in_ready_back",  in_ready_a,  1);
    chk("basic_out_sum_cleared", out_sum_a, 0);

    // ---- backpressure: 1,2,3,4 with gaps, consumer stalled ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_p = 8'd1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_p = 8'd2; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_p = 8'd3; tick();
    in_valid = 1'b0; tick();
    chk("bp_not_yet_valid", out_valid_a, 0);
    in_valid = 1'b1; in_p = 8'd4; tick();
    // Products offered while holding must be ignored.
    in_p = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_out_valid", out_valid_a, 1);
      chk("bp_hold_out_sum",   out_sum_a,   10);
      chk("bp_hold_in_ready",  in_ready_a,  0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", out_valid_a, 0);
    chk("bp_release_in_ready",  in_ready_a,  1);

    // ---- overflow: 225 x4 at W=9 ----
    in_valid = 1'b1; in_p = 8'd225;
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    chk("ovf_w9_out_valid", out_valid_b, 1);
`ifdef SAT_ACCUM_EN
    chk("ovf_w9_out_sum_sat", out_sum_b, 511);
`else
    chk("ovf_w9_out_sum_wrap", out_sum_b, 388);
`endif
    chk("ovf_w9_out_ovf",  out_ovf_b, 1);
    chk("ovf_w10_out_sum", out_sum_a, 900);
    chk("ovf_w10_out_ovf", out_ovf_a, 0);
    tick();
    chk("ovf_w9_ovf_cleared", out_ovf_b, 0);

    // ---- clear mid-frame: 100,100, clear (with 50), then 7 x4 -> 28 ----
    in_valid = 1'b1; in_p = 8'd100;
    tick(); tick();
    clear = 1'b1; in_p = 8'd50;
    tick();
    clear = 1'b0;
    chk("clr_in_ready", in_ready_a, 1);
    chk("clr_out_valid", out_valid_a, 0);
    in_p = 8'd7;
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("clr_out_valid_after", out_valid_a, 1);
    chk("clr_out_sum", out_sum_a, 28);
    // clear in HOLD drops the result even with out_ready high
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_hold_drop_valid", out_valid_a, 0);
    chk("clr_hold_drop_sum",   out_sum_a,   0);

    // ---- async reset in HOLD, then 3 x4 -> 12 ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_p = 8'd50;
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    chk("ar_hold_valid", out_valid_a, 1);
    chk("ar_hold_sum",   out_sum_a,   200);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async_valid", out_valid_a, 0);
    chk("ar_async_sum",   out_sum_a,   0);
    chk("ar_async_ready", in_ready_a,  1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_p = 8'd3;
    tick(); tick(); tick(); tick();
    in_valid = 1'b0;
    chk("ar_next_valid", out_valid_a, 1);
    chk("ar_next_sum",   out_sum_a,   12);
    chk("ar_next_ovf",   out_ovf_a,   0);
    tick();
    chk("ar_next_done", out_valid_a, 0);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
